thiele_logic_bridge: RTL

Parametrised multi-channel bridge between Thiele CPU-side logic-engine requesters and a single external logic engine. It arbitrates `NUM_CH` req/ack channels round-robin, forwards one request at a time to the engine, and returns the engine's data to the granted channel with a one-cycle ack pulse. Unlike the single-channel engine interface it replaces, it adds:
- fairness between channels;
- a per-transaction timeout with error signalling;
- saturating transaction and error counters for the status path.

---
 rtl/thiele_logic_bridge.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/thiele_logic_bridge.sv
// Round-robin bridge from NUM_CH req/ack requesters to one external logic engine,
// with per-transaction timeout and saturating transaction/error counters.
module thiele_logic_bridge #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    output logic [NUM_CH-1:0]        ch_ack,
    output logic [DATA_W-1:0]        ch_data,
    output logic                     ch_err,
    output logic                     eng_req,
    output logic [ADDR_W-1:0]        eng_addr,
    input  logic                     eng_ack,
    input  logic [DATA_W-1:0]        eng_data,
    output logic                     busy,
    output logic [31:0]              xact_count,
    output logic [31:0]              err_count
);

    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_DATA);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [15:0]         wait_q, wait_d;
    logic [ADDR_W-1:0]   eng_addr_q, eng_addr_d;
    logic                eng_req_q, eng_req_d;
    logic [NUM_CH-1:0]   ch_ack_q, ch_ack_d;
    logic [DATA_W-1:0]   ch_data_q, ch_data_d;
    logic                ch_err_q, ch_err_d;
    logic [31:0]         xact_q, xact_d;
    logic [31:0]         errc_q, errc_d;

    logic [NUM_CH-1:0]   eligible;
    logic [NUM_CH-1:0]   grant_oh;
    logic [IDX_W-1:0]    scan_idx;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;
    logic [ADDR_W-1:0]   pick_addr;

    assign eligible = ch_req & ~mask_q;
    assign grant_oh = NUM_CH'(1) << grant_q;

    // First eligible channel at or after rr_ptr, wrapping modulo NUM_CH.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            scan_idx = rr_ptr_q + IDX_W'(i);
            if (!pick_valid && eligible[scan_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        pick_addr = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (IDX_W'(i) == pick_idx) begin
                pick_addr = ch_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        mask_d     = mask_q;
        wait_d     = wait_q;
        eng_addr_d = eng_addr_q;
        eng_req_d  = eng_req_q;
        ch_ack_d   = '0;
        ch_data_d  = ch_data_q;
        ch_err_d   = 1'b0;
        xact_d     = xact_q;
        errc_d     = errc_q;

        unique case (state_q)
            S_IDLE: begin
                // Mask only ever survives a single IDLE cycle.
                mask_d = '0;
                if (pick_valid) begin
                    grant_d    = pick_idx;
                    eng_addr_d = pick_addr;
                    wait_d     = '0;
                    eng_req_d  = 1'b1;
                    state_d    = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // An ack on the timeout cycle takes priority over the abort.
                if (eng_ack) begin
                    ch_data_d = eng_data;
                    ch_err_d  = 1'b0;
                    ch_ack_d  = grant_oh;
                    eng_req_d = 1'b0;
                    state_d   = S_RESP;
                end else if (wait_q == WAIT_LIMIT) begin
                    ch_data_d = ERR_WORD;
                    ch_err_d  = 1'b1;
                    ch_ack_d  = grant_oh;
                    eng_req_d = 1'b0;
                    state_d   = S_RESP;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end

            S_RESP: begin
                if (xact_q != '1) begin
                    xact_d = xact_q + 32'd1;
                end
                if (ch_err_q && (errc_q != '1)) begin
                    errc_d = errc_q + 32'd1;
                end
                rr_ptr_d = grant_q + IDX_W'(1);
                mask_d   = grant_oh;
                state_d  = S_IDLE;
            end

            default: begin
                eng_req_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            mask_q     <= '0;
            wait_q     <= '0;
            eng_addr_q <= '0;
            eng_req_q  <= 1'b0;
            ch_ack_q   <= '0;
            ch_data_q  <= '0;
            ch_err_q   <= 1'b0;
            xact_q     <= '0;
            errc_q     <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            mask_q     <= mask_d;
            wait_q     <= wait_d;
            eng_addr_q <= eng_addr_d;
            eng_req_q  <= eng_req_d;
            ch_ack_q   <= ch_ack_d;
            ch_data_q  <= ch_data_d;
            ch_err_q   <= ch_err_d;
            xact_q     <= xact_d;
            errc_q     <= errc_d;
        end
    end

    assign ch_ack     = ch_ack_q;
    assign ch_data    = ch_data_q;
    assign ch_err     = ch_err_q;
    assign eng_req    = eng_req_q;
    assign eng_addr   = eng_addr_q;
    assign busy       = (state_q != S_IDLE);
    assign xact_count = xact_q;
    assign err_count  = errc_q;

endmodule
